onehot_ring_monitor: RTL and testbench

ONEHOT_RING_MONITOR -- requirements
Module: onehot_ring_monitor

---
 rtl/ring_pkg.sv | 19 +
 rtl/onehot_dec.sv | 25 ++
 rtl/onehot_ring_monitor.sv | 123 ++++++++++++
 tb/tb_onehot_ring_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types for the one-hot ring monitor: FSM states, error codes and
// the default ring width.
package ring_pkg;

  localparam int NBITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ONEHOT = 2'd1,
    ERR_STEP   = 2'd2
  } err_code_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational classifier for one ring sample: zero, exactly-one-hot, and
// the binary position of the set bit (only meaningful when one-hot).
module onehot_dec #(
  parameter  int nbits = 4,
  localparam int IW    = $clog2(nbits)
) (
  input  logic [nbits-1:0] code,
  output logic             is_onehot,
  output logic             is_zero,
  output logic [IW-1:0]    index
);

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign is_zero   = (code == '0);
  assign is_onehot = !is_zero && ((code & (code - nbits'(1))) == '0);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    index = '0;
    for (int i = 0; i < nbits; i++) begin
      if (code[i]) index = index | IW'(i);
    end
  end

endmodule

// File: rtl/onehot_ring_monitor.sv
// Watches a one-hot ring counter, reports its position, counts revolutions and
// latches a sticky error. Define RING_HOLD_EN to accept a repeated code as a hold.
module onehot_ring_monitor
  import ring_pkg::*;
#(
  parameter  int nbits = NBITS_DEFAULT,
  localparam int IW    = $clog2(nbits)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [nbits-1:0] ring,
  input  logic             clear,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [7:0]       revs
);

  if (nbits < 2 || (nbits & (nbits - 1)) != 0) begin : g_bad_nbits
    $error("onehot_ring_monitor: nbits must be a power of two and at least 2");
  end

  state_t    state;
  err_code_t err_code_q;

  logic          dec_onehot;
  logic          dec_zero;
  logic [IW-1:0] dec_idx;

  onehot_dec #(.nbits(nbits)) u_dec (
    .code      (ring),
    .is_onehot (dec_onehot),
    .is_zero   (dec_zero),
    .index     (dec_idx)
  );

  // The previous code is always 1 << index while tracking, so a rotate-left
  // step is simply index+1 (wrapping because nbits is a power of two).
  logic [IW-1:0] next_idx;
  logic          step_ok;
  logic          reload;
  logic          wrap;
  logic          hold_ok;

  assign next_idx = index + IW'(1);
  assign step_ok  = (dec_idx == next_idx);
  assign reload   = (dec_idx == '0);
  assign wrap     = (dec_idx == '0) && (index == '1);

`ifdef RING_HOLD_EN
  assign hold_ok = (dec_idx == index);
`else
  assign hold_ok = 1'b0;
`endif

  assign err_code = err_code_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      index       <= '0;
      index_valid <= 1'b0;
      err         <= 1'b0;
      err_code_q  <= ERR_NONE;
      revs        <= '0;
    end else if (clear) begin
      state       <= S_IDLE;
      index_valid <= 1'b0;
      err         <= 1'b0;
      err_code_q  <= ERR_NONE;
      revs        <= '0;
    end else if (valid) begin
      if (dec_zero) begin
        // The ring itself was reset: drop the reference, keep error history.
        state       <= S_IDLE;
        index_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (dec_onehot) begin
              state       <= S_TRACK;
              index       <= dec_idx;
              index_valid <= 1'b1;
            end else begin
              state       <= S_ERR;
              index_valid <= 1'b0;
              err         <= 1'b1;
              err_code_q  <= ERR_ONEHOT;
            end
          end
          S_TRACK: begin
            if (!dec_onehot) begin
              state       <= S_ERR;
              index_valid <= 1'b0;
              err         <= 1'b1;
              err_code_q  <= ERR_ONEHOT;
            end else if (step_ok || reload) begin
              index <= dec_idx;
              if (wrap) revs <= revs + 8'd1;
            end else if (!hold_ok) begin
              state       <= S_ERR;
              index_valid <= 1'b0;
              err         <= 1'b1;
              err_code_q  <= ERR_STEP;
            end
          end
          S_ERR: begin
            // Sticky until clear; only an all-zero ring leaves this state.
          end
          default: begin
            state       <= S_IDLE;
            index_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onehot_ring_monitor.sv
// Self-checking bench for onehot_ring_monitor (nbits=4): a vector-level model
// checked every cycle, plus hand-computed expectations on directed sequences.
module tb_onehot_ring_monitor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid = 1'b0;
  logic [N-1:0] ring = '0;
  logic         clear = 1'b0;
  logic [1:0]   index;
  logic         index_valid;
  logic         err;
  logic [1:0]   err_code;
  logic [7:0]   revs;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  onehot_ring_monitor #(.nbits(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .ring        (ring),
    .clear       (clear),
    .index       (index),
    .index_valid (index_valid),
    .err         (err),
    .err_code    (err_code),
    .revs        (revs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: keeps the previous code as a vector and judges each sample by
  // rotating that vector, counting set bits and taking log2 of the code.
  int           m_mode;   // 0 no reference, 1 following, 2 faulted
  int           m_idx, m_iv, m_err, m_code, m_revs;
  logic [N-1:0] m_prev;

  always @(posedge clk or negedge reset) begin
    logic [N-1:0] rot;
    bit           hold;
    if (!reset) begin
      m_mode = 0; m_idx = 0; m_iv = 0; m_err = 0; m_code = 0; m_revs = 0; m_prev = '0;
    end else if (clear) begin
      m_mode = 0; m_iv = 0; m_err = 0; m_code = 0; m_revs = 0;
    end else if (valid) begin
      rot = (m_prev << 1) | (m_prev >> (N - 1));
`ifdef RING_HOLD_EN
      hold = (ring == m_prev);
`else
      hold = 1'b0;
`endif
      if ($countones(ring) == 0) begin
        m_mode = 0; m_iv = 0;
      end else if (m_mode == 2) begin
        // faulted: ignore
      end else if ($countones(ring) > 1) begin
        m_mode = 2; m_iv = 0; m_err = 1; m_code = 1;
      end else if (m_mode == 0) begin
        m_mode = 1; m_prev = ring; m_idx = $clog2(ring); m_iv = 1;
      end else if (ring == rot || ring == 1) begin
        if (ring == 1 && m_prev == (1 << (N - 1))) m_revs = (m_revs + 1) % 256;
        m_prev = ring; m_idx = $clog2(ring);
      end else if (!hold) begin
        m_mode = 2; m_iv = 0; m_err = 1; m_code = 2;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("cyc_index", index, m_idx);
      check("cyc_index_valid", index_valid, m_iv);
      check("cyc_err", err, m_err);
      check("cyc_err_code", err_code, m_code);
      check("cyc_revs", revs, m_revs);
    end
  end

  task automatic cyc(input logic v, input logic [N-1:0] r, input logic c);
    @(negedge clk);
    valid = v; ring = r; clear = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] seq [6];
    int           exp_idx [6];
    seq = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2};
    exp_idx = '{0, 1, 2, 3, 0, 1};

    repeat (2) @(posedge clk);
    #2;
    check("rst_index", index, 0);
    check("rst_index_valid", index_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_revs", revs, 0);
    @(negedge clk);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Normal rotation with one wrap
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, seq[i], 1'b0);
      check($sformatf("rot_index_%0d", i), index, exp_idx[i]);
      check($sformatf("rot_iv_%0d", i), index_valid, 1);
    end
    check("rot_revs", revs, 1);
    check("rot_err", err, 0);

    // valid low holds everything even with a bad code on the bus
    cyc(1'b0, 4'b0110, 1'b0);
    check("idle_hold_index", index, 1);
    check("idle_hold_err", err, 0);

    // Illegal step, ignored samples, clear
    cyc(1'b1, 4'd8, 1'b0);
    check("step_err", err, 1);
    check("step_code", err_code, 2);
    check("step_iv", index_valid, 0);
    cyc(1'b1, 4'd4, 1'b0);
    cyc(1'b1, 4'd8, 1'b0);
    check("err_ignored_index", index, 1);
    check("err_ignored_iv", index_valid, 0);
    cyc(1'b0, 4'd0, 1'b1);
    check("clear_err", err, 0);
    check("clear_revs", revs, 0);

    // Not one-hot from idle, then ring reset keeps err
    cyc(1'b1, 4'b0110, 1'b0);
    check("oh_err", err, 1);
    check("oh_code", err_code, 1);
    cyc(1'b1, 4'd0, 1'b0);
    check("zero_err_sticky", err, 1);
    check("zero_iv", index_valid, 0);
    cyc(1'b0, 4'd0, 1'b1);

    // Not one-hot while tracking
    cyc(1'b1, 4'd1, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    check("trk_oh_code", err_code, 1);
    cyc(1'b0, 4'd0, 1'b1);

    // Reload from the middle, then 256 revolutions
    cyc(1'b1, 4'd1, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
    cyc(1'b1, 4'd4, 1'b0);
    cyc(1'b1, 4'd1, 1'b0);
    check("reload_index", index, 0);
    check("reload_err", err, 0);
    check("reload_revs", revs, 0);
    for (int r = 0; r < 256; r++) begin
      cyc(1'b1, 4'd2, 1'b0);
      cyc(1'b1, 4'd4, 1'b0);
      cyc(1'b1, 4'd8, 1'b0);
      cyc(1'b1, 4'd1, 1'b0);
      if (r == 254) check("revs_255", revs, 255);
    end
    check("revs_wrap", revs, 0);
    check("revs_wrap_err", err, 0);

    // Repeated code
    cyc(1'b1, 4'd2, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
`ifdef RING_HOLD_EN
    check("repeat_err", err, 0);
    check("repeat_index", index, 1);
`else
    check("repeat_err", err, 1);
    check("repeat_code", err_code, 2);
`endif
    cyc(1'b0, 4'd0, 1'b1);

    // Clear wins over a simultaneous sample
    cyc(1'b1, 4'd1, 1'b1);
    check("clear_prio_iv", index_valid, 0);
    cyc(1'b1, 4'd2, 1'b0);
    check("after_clear_index", index, 1);
    check("after_clear_iv", index_valid, 1);
    cyc(1'b0, 4'd0, 1'b1);

    // Asynchronous reset mid-count discards history
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'd1 << (i % 4), 1'b0);
    check("pre_rst_revs", revs, 1);
    @(negedge clk);
    valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("async_rst_iv", index_valid, 0);
    check("async_rst_revs", revs, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 4'd4, 1'b0);
    check("post_rst_index", index, 2);
    check("post_rst_iv", index_valid, 1);
    check("post_rst_err", err, 0);
    check("post_rst_revs", revs, 0);

    cyc(1'b0, 4'd0, 1'b0);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
